// File: rtl/shift_pkg.sv
// Shared op-field encodings, special-case codes and width helper for the shifter-operand pipeline.
package shift_pkg;

  localparam logic [1:0] KIND_LSL = 2'b00;
  localparam logic [1:0] KIND_LSR = 2'b01;
  localparam logic [1:0] KIND_ASR = 2'b10;
  localparam logic [1:0] KIND_ROR = 2'b11;

  localparam int unsigned OP_REG_BIT = 0;
  localparam logic [3:0]  OP_IMMED   = 4'b1000;

  typedef enum logic [2:0] {
    SpecPass,
    SpecZero,
    SpecSign,
    SpecRrx,
    SpecShift,
    SpecRot
  } special_e;

  function automatic int unsigned shift_n(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shifter datapath; every out-of-range case has already been folded into `special`.
module shift_core
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N      = 5
) (
  input  logic [1:0]        kind,
  input  logic [N-1:0]      k,
  input  special_e          special,
  input  logic [DATA_W-1:0] s,
  input  logic              c,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W-1:0] rot;
  logic [N-1:0]      k_minus_1;
  logic [N-1:0]      w_minus_k;

  always_comb begin
    rot       = DATA_W'({s, s} >> k);
    k_minus_1 = k - N'(1);
    w_minus_k = N'(0) - k;
    result    = s;
    carry     = c;
    unique case (special)
      SpecPass: begin
        result = s;
        carry  = c;
      end
      // k[0] selects whether the edge bit or zero becomes the carry
      SpecZero: begin
        result = '0;
        carry  = k[0] & ((kind == KIND_LSL) ? s[0] : s[DATA_W-1]);
      end
      SpecSign: begin
        result = {DATA_W{s[DATA_W-1]}};
        carry  = s[DATA_W-1];
      end
      SpecRrx: begin
        result = {c, s[DATA_W-1:1]};
        carry  = s[0];
      end
      SpecShift: begin
        case (kind)
          KIND_LSL: begin
            result = s << k;
            carry  = s[w_minus_k];
          end
          KIND_LSR: begin
            result = s >> k;
            carry  = s[k_minus_1];
          end
          KIND_ASR: begin
            result = DATA_W'($signed(s) >>> k);
            carry  = s[k_minus_1];
          end
          default: begin
            result = rot;
            carry  = rot[DATA_W-1];
          end
        endcase
      end
      SpecRot: begin
        result = rot;
        carry  = rot[DATA_W-1];
      end
      default: begin
        result = s;
        carry  = c;
      end
    endcase
  end

endmodule

// File: rtl/shift_pipe_unit.sv
// Pipelined ARM shifter-operand unit with valid/ready handshake (1 or 2 stages).
// Defining SHIFT_NZ_FLAGS_EN adds registered out_n / out_z result flags.
module shift_pipe_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AMT_W   = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_shiftee,
  input  logic [AMT_W-1:0]  in_amount,
  input  logic              in_c_flag,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHIFT_NZ_FLAGS_EN
  ,
  output logic              out_n,
  output logic              out_z
`endif
);

  localparam int unsigned N = shift_n(DATA_W);

  logic [1:0]   kind_d;
  logic [N-1:0] k_d;
  special_e     spec_d;
  logic [31:0]  a_ext;
  logic [N-1:0] amt_imm;

  always_comb begin
    kind_d  = in_op[2:1];
    k_d     = '0;
    spec_d  = SpecPass;
    amt_imm = in_amount[N-1:0];
    a_ext   = 32'(in_amount[7:0]);
    if (in_op == OP_IMMED) begin
      kind_d = KIND_ROR;
      k_d    = {in_amount[N-2:0], 1'b0};
      spec_d = (in_amount[N-2:0] == '0) ? SpecPass : SpecRot;
    end else if (!in_op[OP_REG_BIT]) begin
      k_d = amt_imm;
      case (in_op[2:1])
        KIND_LSL: spec_d = (amt_imm == '0) ? SpecPass : SpecShift;
        KIND_LSR: begin
          spec_d = (amt_imm == '0) ? SpecZero : SpecShift;
          if (amt_imm == '0) k_d = N'(1);
        end
        KIND_ASR: spec_d = (amt_imm == '0) ? SpecSign : SpecShift;
        default:  spec_d = (amt_imm == '0) ? SpecRrx : SpecRot;
      endcase
    end else begin
      k_d = in_amount[N-1:0];
      if (a_ext == 32'd0) begin
        spec_d = SpecPass;
      end else begin
        case (in_op[2:1])
          KIND_LSL, KIND_LSR: begin
            if (a_ext < DATA_W) begin
              spec_d = SpecShift;
            end else begin
              spec_d = SpecZero;
              k_d    = (a_ext == DATA_W) ? N'(1) : N'(0);
            end
          end
          KIND_ASR: spec_d = (a_ext < DATA_W) ? SpecShift : SpecSign;
          // multiples of W land on k=0, which the rotator treats as identity with carry s[W-1]
          default:  spec_d = SpecRot;
        endcase
      end
    end
  end

  logic              feed_valid;
  logic [1:0]        feed_kind;
  logic [N-1:0]      feed_k;
  special_e          feed_spec;
  logic [DATA_W-1:0] feed_s;
  logic              feed_c;
  logic [TAG_W-1:0]  feed_tag;
  logic              out_valid_q;
  logic              out_stage_ready;

  assign out_stage_ready = !out_valid_q || out_ready;

  if (LATENCY == 1) begin : g_lat1
    assign feed_valid = in_valid;
    assign feed_kind  = kind_d;
    assign feed_k     = k_d;
    assign feed_spec  = spec_d;
    assign feed_s     = in_shiftee;
    assign feed_c     = in_c_flag;
    assign feed_tag   = in_tag;
    assign in_ready   = out_stage_ready;
  end else begin : g_lat2
    logic              v1_q;
    logic [1:0]        kind_q;
    logic [N-1:0]      k_q;
    special_e          spec_q;
    logic [DATA_W-1:0] s_q;
    logic              c_q;
    logic [TAG_W-1:0]  tag_q;
    logic              stage1_ready;

    assign stage1_ready = !v1_q || out_stage_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q   <= 1'b0;
        kind_q <= '0;
        k_q    <= '0;
        spec_q <= SpecPass;
        s_q    <= '0;
        c_q    <= 1'b0;
        tag_q  <= '0;
      end else if (stage1_ready) begin
        v1_q <= in_valid;
        if (in_valid) begin
          kind_q <= kind_d;
          k_q    <= k_d;
          spec_q <= spec_d;
          s_q    <= in_shiftee;
          c_q    <= in_c_flag;
          tag_q  <= in_tag;
        end
      end
    end

    assign feed_valid = v1_q;
    assign feed_kind  = kind_q;
    assign feed_k     = k_q;
    assign feed_spec  = spec_q;
    assign feed_s     = s_q;
    assign feed_c     = c_q;
    assign feed_tag   = tag_q;
    assign in_ready   = stage1_ready;
  end

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("shift_pipe_unit: LATENCY must be 1 or 2");
  end

  logic [DATA_W-1:0] core_result;
  logic              core_carry;

  shift_core #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_core (
    .kind    (feed_kind),
    .k       (feed_k),
    .special (feed_spec),
    .s       (feed_s),
    .c       (feed_c),
    .result  (core_result),
    .carry   (core_carry)
  );

  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [TAG_W-1:0]  out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      out_tag_q   <= '0;
    end else if (out_stage_ready) begin
      out_valid_q <= feed_valid;
      if (feed_valid) begin
        result_q  <= core_result;
        carry_q   <= core_carry;
        out_tag_q <= feed_tag;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_tag    = out_tag_q;

`ifdef SHIFT_NZ_FLAGS_EN
  logic n_q;
  logic z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (out_stage_ready && feed_valid) begin
      n_q <= core_result[DATA_W-1];
      z_q <= (core_result == '0);
    end
  end

  assign out_n = n_q;
  assign out_z = z_q;
`endif

endmodule
